// File: rtl/muldiv_execution_unit_pkg.sv
// Core-wide shared types for the out-of-order pipeline: reservation-station entry, CDB lane, M-extension op/state enums.
package oops_structs;

  localparam int OOPS_XLEN              = 32;
  localparam int ROB_TAG_W              = 5;
  localparam int MULDIV_MAX_MUL_LATENCY = 8;

  // Encoding matches RV32M funct3 so the decoder can pass it straight through.
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  typedef struct packed {
    muldiv_op_t            op;
    logic [OOPS_XLEN-1:0]  val1;
    logic [OOPS_XLEN-1:0]  val2;
    logic [ROB_TAG_W-1:0]  rob_dest;
  } reservation_station_element_t;

  typedef struct packed {
    logic                  valid;
    logic [OOPS_XLEN-1:0]  data;
    logic [ROB_TAG_W-1:0]  ROB_dest;
  } common_data_lane_t;

endpackage

// File: rtl/muldiv_execution_unit_divider.sv
// Iterative radix-2 restoring divider on unsigned operands, one quotient bit per cycle.
// done is high during the last iteration; quotient_nxt/remainder_nxt then carry the final values.
module radix2_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient_nxt,
  output logic [XLEN-1:0] remainder_nxt
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] dvs_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;

  // Partial remainder needs one extra bit: 2*rem+1 can exceed XLEN bits.
  always_comb begin
    rem_sh = {rem_r, quo_r[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_r};
    if (!diff[XLEN]) begin
      remainder_nxt = diff[XLEN-1:0];
      quotient_nxt  = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      remainder_nxt = rem_sh[XLEN-1:0];
      quotient_nxt  = {quo_r[XLEN-2:0], 1'b0};
    end
  end

  assign done = (cnt_r == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_r <= '0;
      rem_r <= '0;
      dvs_r <= '0;
      cnt_r <= '0;
    end else if (abort) begin
      cnt_r <= '0;
    end else if (start) begin
      quo_r <= dividend;
      rem_r <= '0;
      dvs_r <= divisor;
      cnt_r <= CW'(XLEN);
    end else if (cnt_r != '0) begin
      quo_r <= quotient_nxt;
      rem_r <= remainder_nxt;
      cnt_r <= cnt_r - CW'(1);
    end
  end

endmodule

// File: rtl/muldiv_execution_unit.sv
// RV32M multiply/divide execution unit: fixed-latency multiply, iterative divide, result held until CDB grant.
// Optional `MULDIV_EARLY_OUT_EN: trivial operands (zero, divide-by-zero, signed overflow) finish in one cycle.
module muldiv_execution_unit
  import oops_structs::*;
#(
  parameter int XLEN        = OOPS_XLEN,
  parameter int MUL_LATENCY = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic                          vld_i,
  output logic                          rdy_i,
  input  reservation_station_element_t  data_i,
  input  logic                          gnt_i,
  output common_data_lane_t             data_o
);

  if (MUL_LATENCY < 1 || MUL_LATENCY > MULDIV_MAX_MUL_LATENCY) begin : g_bad_latency
    $error("muldiv_execution_unit: MUL_LATENCY must be within 1..%0d", MULDIV_MAX_MUL_LATENCY);
  end
  if (XLEN != OOPS_XLEN || XLEN % 8 != 0) begin : g_bad_xlen
    $error("muldiv_execution_unit: XLEN must match the shared lane width and be a multiple of 8");
  end

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t         state;
  muldiv_op_t            op_q;
  logic [XLEN-1:0]       a_q;
  logic [XLEN-1:0]       b_q;
  logic [ROB_TAG_W-1:0]  rob_q;
  logic [3:0]            cnt_q;
  logic                  accept;
  logic                  div_start;
  logic                  div_done;
  logic [XLEN-1:0]       div_a_abs;
  logic [XLEN-1:0]       div_b_abs;
  logic [XLEN-1:0]       quo_nxt;
  logic [XLEN-1:0]       rem_nxt;
  logic                  early_out;
  logic [XLEN-1:0]       early_res;

  function automatic logic is_signed_div(input muldiv_op_t op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic [XLEN-1:0] mul_result(input muldiv_op_t op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    a_ext = (op == MD_MULH || op == MD_MULHSU) ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    b_ext = (op == MD_MULH) ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    prod  = a_ext * b_ext;
    return (op == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // q/r are the unsigned magnitudes; overflow falls out naturally since -INT_MIN wraps to INT_MIN.
  function automatic logic [XLEN-1:0] div_fix(input muldiv_op_t op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b,
                                              input logic [XLEN-1:0] q,
                                              input logic [XLEN-1:0] r);
    logic is_rem;
    logic a_neg;
    logic b_neg;
    is_rem = (op == MD_REM) || (op == MD_REMU);
    a_neg  = is_signed_div(op) & a[XLEN-1];
    b_neg  = is_signed_div(op) & b[XLEN-1];
    if (b == '0) return is_rem ? a : '1;
    if (is_rem) return a_neg ? -r : r;
    return (a_neg ^ b_neg) ? -q : q;
  endfunction

  assign rdy_i  = (state == IDLE) && !flush_i;
  assign accept = vld_i && rdy_i;

  always_comb begin
    early_out = 1'b0;
    early_res = '0;
`ifdef MULDIV_EARLY_OUT_EN
    if (data_i.op[2]) begin
      early_out = (data_i.val2 == '0) ||
                  (is_signed_div(data_i.op) && data_i.val1 == INT_MIN && data_i.val2 == '1);
      early_res = div_fix(data_i.op, data_i.val1, data_i.val2, INT_MIN, '0);
    end else begin
      early_out = (data_i.val1 == '0) || (data_i.val2 == '0);
    end
`endif
  end

  always_comb begin
    div_a_abs = data_i.val1;
    div_b_abs = data_i.val2;
    if (is_signed_div(data_i.op) && data_i.val1[XLEN-1]) div_a_abs = -data_i.val1;
    if (is_signed_div(data_i.op) && data_i.val2[XLEN-1]) div_b_abs = -data_i.val2;
  end

  assign div_start = accept && data_i.op[2] && !early_out;

  radix2_divider #(.XLEN(XLEN)) u_divider (
    .clk           (clk),
    .rst           (rst),
    .start         (div_start),
    .abort         (flush_i),
    .dividend      (div_a_abs),
    .divisor       (div_b_abs),
    .done          (div_done),
    .quotient_nxt  (quo_nxt),
    .remainder_nxt (rem_nxt)
  );

  // cnt_q counts cycles since accept, so MUL reaches DONE exactly MUL_LATENCY cycles later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= MD_MUL;
      a_q    <= '0;
      b_q    <= '0;
      rob_q  <= '0;
      cnt_q  <= '0;
      data_o <= '0;
    end else if (flush_i) begin
      state        <= IDLE;
      data_o.valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vld_i) begin
            op_q  <= data_i.op;
            a_q   <= data_i.val1;
            b_q   <= data_i.val2;
            rob_q <= data_i.rob_dest;
            cnt_q <= 4'd1;
            if (early_out) begin
              state  <= DONE;
              data_o <= '{valid: 1'b1, data: early_res, ROB_dest: data_i.rob_dest};
            end else if (data_i.op[2]) begin
              state <= DIV;
            end else if (MUL_LATENCY == 1) begin
              state  <= DONE;
              data_o <= '{valid: 1'b1,
                          data: mul_result(data_i.op, data_i.val1, data_i.val2),
                          ROB_dest: data_i.rob_dest};
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (cnt_q == 4'(MUL_LATENCY - 1)) begin
            state  <= DONE;
            data_o <= '{valid: 1'b1, data: mul_result(op_q, a_q, b_q), ROB_dest: rob_q};
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        DIV: begin
          if (div_done) begin
            state  <= DONE;
            data_o <= '{valid: 1'b1, data: div_fix(op_q, a_q, b_q, quo_nxt, rem_nxt), ROB_dest: rob_q};
          end
        end
        DONE: begin
          if (gnt_i) begin
            state        <= IDLE;
            data_o.valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
